// File: rtl/imem_pkg.sv
// Shared types and address helpers for the instruction-memory fetch port.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    // Word index of a byte address, for an array with iw index bits.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input int iw);
        return (addr >> 2) & ((64'd1 << iw) - 64'd1);
    endfunction

    // Misaligned, or any bit above the array's byte span set within an aw-bit address.
    function automatic logic addr_err(input logic [63:0] addr, input int iw, input int aw);
        logic [63:0] hi_mask;
        hi_mask = (64'd1 << (aw - iw - 2)) - 64'd1;
        return (addr[1:0] != 2'b00) || (((addr >> (iw + 2)) & hi_mask) != 64'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-write / single-read instruction storage with registered, write-first read.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata_p1,
    output logic                     rerr_p1
);

`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] wword;
    logic [MW-1:0] rword;

`ifdef IMEM_PARITY_EN
    assign wword = {^wdata, wdata};
`else
    assign wword = wdata;
`endif

    // A write landing on the word being read wins over the stored copy.
    assign rword = (we && (waddr == raddr)) ? wword : mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
        if (re) begin
            rdata_p1 <= rword[DATA_WIDTH-1:0];
        end
    end

`ifdef IMEM_PARITY_EN
    // Stored word plus its parity bit must XOR to zero.
    always_ff @(posedge clk) begin
        if (re) begin
            rerr_p1 <= ^rword;
        end
    end
`else
    assign rerr_p1 = 1'b0;
`endif

endmodule

// File: rtl/imem_fetch_port.sv
// Fetch-stage instruction memory: valid/ready PC requests, LATENCY wait states, flush, loader port.
// Optional parity checking is enabled by defining IMEM_PARITY_EN.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter int                    LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(NOP_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_instr,
    output logic                     resp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    fetch_state_e    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q;
    logic            perr_q;
    logic            rerr_q;

    logic [IW-1:0]   idx_now;
    logic            err_now;
    logic            accept;
    logic            enter_resp;
    logic            err_sel;
    logic [IW-1:0]   rd_idx;
    logic [DATA_WIDTH-1:0] arr_data_p1;
    logic            arr_perr_p1;

    assign idx_now   = IW'(word_index(64'(req_addr), IW));
    assign err_now   = addr_err(64'(req_addr), IW, ADDR_WIDTH);
    assign req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: ;
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Accept only happens from IDLE or a completing RESP, so it overrides the above.
        if (accept) begin
            cnt_d      = CW'(LATENCY - 1);
            state_d    = (LATENCY == 1) ? RESP : WAIT;
            enter_resp = (LATENCY == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                perr_q <= err_now;
            end
            if (enter_resp) begin
                rerr_q <= err_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= idx_now;
        end
    end

    // With LATENCY==1 the read launches on the accept edge, straight from req_addr.
    assign err_sel = accept ? err_now : perr_q;
    assign rd_idx  = accept ? idx_now : idx_q;

    imem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (ld_we),
        .waddr   (ld_addr),
        .wdata   (ld_data),
        .re      (enter_resp && !err_sel),
        .raddr   (rd_idx),
        .rdata_p1(arr_data_p1),
        .rerr_p1 (arr_perr_p1)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && (rerr_q || arr_perr_p1);
    assign resp_instr = !resp_valid ? '0 : (resp_err ? NOP_WORD : arr_data_p1);

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port with LATENCY 1, 3 and 4 instances sharing clock, reset and loader.
module tb_imem_fetch_port;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    logic            clk;
    logic            rst_n;
    logic            rv [3];
    logic            fl [3];
    logic            rr [3];
    logic [AW-1:0]   ra [3];
    logic            rq [3];
    logic            vo [3];
    logic            eo [3];
    logic [DW-1:0]   io [3];
    logic            ld_we;
    logic [IW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;

    int n_cmp;
    int n_err;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_fetch_port #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .DEPTH     (DEPTH),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .NOP_WORD  (32'h0000_0000)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (rv[g]),
            .req_ready (rq[g]),
            .req_addr  (ra[g]),
            .flush     (fl[g]),
            .resp_valid(vo[g]),
            .resp_ready(rr[g]),
            .resp_instr(io[g]),
            .resp_err  (eo[g]),
            .ld_we     (ld_we),
            .ld_addr   (ld_addr),
            .ld_data   (ld_data)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = IW'(idx);
        ld_data = data;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    // Issue one request to instance k from IDLE and measure latency and payload.
    task automatic fetch(input int k, input logic [31:0] addr, input int lat,
                         input logic [31:0] ins, input logic err, input string tag);
        int          first;
        logic [31:0] ci;
        logic        ce;
        first = 0;
        ci    = '0;
        ce    = 1'b0;
        rv[k] = 1'b1;
        ra[k] = addr;
        rr[k] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            rv[k] = 1'b0;
            if (vo[k] && (first == 0)) begin
                first = i;
                ci    = io[k];
                ce    = eo[k];
            end
        end
        chk({tag, "_lat"}, 32'(first), 32'(lat));
        chk({tag, "_instr"}, ci, ins);
        chk({tag, "_err"}, {31'd0, ce}, {31'd0, err});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0;
            fl[k] = 1'b0;
            rr[k] = 1'b0;
            ra[k] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'd0, vo[k]}, 32'd0);
            chk($sformatf("rst_instr%0d", k), io[k], 32'd0);
            chk($sformatf("rst_err%0d", k), {31'd0, eo[k]}, 32'd0);
            chk($sformatf("rst_ready%0d", k), {31'd0, rq[k]}, 32'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        load(0, 32'h2008_0000);
        load(1, 32'h2108_FFFF);
        load(2, 32'hAAAA_5555);
        load(3, 32'h0123_4567);
        load(5, 32'hDEAD_BEEF);
        load(1023, 32'h5A5A_C3C3);

        // LATENCY 1 back-to-back
        rv[0] = 1'b1; ra[0] = 32'd0; rr[0] = 1'b1;
        #1 chk("t1_ready_idle", {31'd0, rq[0]}, 32'd1);
        @(negedge clk);
        chk("t1_v0", {31'd0, vo[0]}, 32'd1);
        chk("t1_i0", io[0], 32'h2008_0000);
        chk("t1_e0", {31'd0, eo[0]}, 32'd0);
        ra[0] = 32'd4;
        #1 chk("t1_ready_b2b", {31'd0, rq[0]}, 32'd1);
        @(negedge clk);
        chk("t1_v1", {31'd0, vo[0]}, 32'd1);
        chk("t1_i1", io[0], 32'h2108_FFFF);
        chk("t1_e1", {31'd0, eo[0]}, 32'd0);
        rv[0] = 1'b0;
        @(negedge clk);
        chk("t1_idle", {31'd0, vo[0]}, 32'd0);

        // LATENCY 3 timing and stalled req_ready
        rv[1] = 1'b1; ra[1] = 32'd8; rr[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0;
        chk("t2_v_w1", {31'd0, vo[1]}, 32'd0);
        chk("t2_rdy_w1", {31'd0, rq[1]}, 32'd0);
        @(negedge clk);
        chk("t2_v_w2", {31'd0, vo[1]}, 32'd0);
        chk("t2_rdy_w2", {31'd0, rq[1]}, 32'd0);
        @(negedge clk);
        chk("t2_v", {31'd0, vo[1]}, 32'd1);
        chk("t2_i", io[1], 32'hAAAA_5555);
        chk("t2_e", {31'd0, eo[1]}, 32'd0);
        @(negedge clk);
        chk("t2_idle", {31'd0, vo[1]}, 32'd0);

        // Address errors and the last valid word
        fetch(0, 32'h0000_0006, 1, 32'h0, 1'b1, "t3_misaligned");
        fetch(0, 32'h0000_1000, 1, 32'h0, 1'b1, "t3_range");
        fetch(0, 32'h8000_0000, 1, 32'h0, 1'b1, "t3_msb");
        fetch(0, 32'h0000_0FFC, 1, 32'h5A5A_C3C3, 1'b0, "t3_last");

        // Stalled response with a loader write to the held word
        rv[0] = 1'b1; ra[0] = 32'd12; rr[0] = 1'b0;
        @(negedge clk);
        rv[0] = 1'b0;
        ld_we = 1'b1; ld_addr = 10'd3; ld_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_v%0d", i), {31'd0, vo[0]}, 32'd1);
            chk($sformatf("t4_i%0d", i), io[0], 32'h0123_4567);
            chk($sformatf("t4_rdy%0d", i), {31'd0, rq[0]}, 32'd0);
            @(negedge clk);
            ld_we = 1'b0;
        end
        rr[0] = 1'b1;
        #1 chk("t4_rdy_release", {31'd0, rq[0]}, 32'd1);
        @(negedge clk);
        chk("t4_idle", {31'd0, vo[0]}, 32'd0);
        fetch(0, 32'd12, 1, 32'hFFFF_FFFF, 1'b0, "t4_newdata");

        // Write-first on the edge entering RESP
        rv[0] = 1'b1; ra[0] = 32'd20; rr[0] = 1'b1;
        ld_we = 1'b1; ld_addr = 10'd5; ld_data = 32'h1357_9BDF;
        @(negedge clk);
        rv[0] = 1'b0; ld_we = 1'b0;
        chk("t4_wf_v", {31'd0, vo[0]}, 32'd1);
        chk("t4_wf_i", io[0], 32'h1357_9BDF);
        @(negedge clk);

        // LATENCY 4 flush mid-wait
        rv[2] = 1'b1; ra[2] = 32'd4; rr[2] = 1'b1;
        @(negedge clk);
        rv[2] = 1'b0;
        @(negedge clk);
        fl[2] = 1'b1;
        #1 chk("t5_rdy_flush", {31'd0, rq[2]}, 32'd0);
        @(negedge clk);
        fl[2] = 1'b0;
        chk("t5_v_after", {31'd0, vo[2]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t5_none%0d", i), {31'd0, vo[2]}, 32'd0);
        end
        fetch(2, 32'd0, 4, 32'h2008_0000, 1'b0, "t5_next");

        // Reset mid-wait keeps memory
        rv[1] = 1'b1; ra[1] = 32'd12; rr[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0;
        chk("t6_rdy_wait", {31'd0, rq[1]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_v_rst", {31'd0, vo[1]}, 32'd0);
        chk("t6_rdy_rst", {31'd0, rq[1]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(1, 32'd4, 3, 32'h2108_FFFF, 1'b0, "t6_mem1");
        fetch(1, 32'd12, 3, 32'hFFFF_FFFF, 1'b0, "t6_mem3");

`ifdef IMEM_PARITY_EN
        g_dut[0].u_dut.u_array.mem[2] = g_dut[0].u_dut.u_array.mem[2] ^ 33'd1;
        fetch(0, 32'd8, 1, 32'h0, 1'b1, "t7_parity");
        fetch(0, 32'd4, 1, 32'h2108_FFFF, 1'b0, "t7_clean");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
